// File: rtl/inverter_test_sequencer_pkg.sv
// Shared constants for the inverter self-test sequencer: FSM state codes,
// status sentinels and the saturating error-count helper.
package inverter_test_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [7:0] FAIL_NONE = 8'hFF;
  localparam logic [7:0] ERR_MAX   = 8'd255;

  // Error counter increment that sticks at ERR_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    logic [7:0] res;
    if (cnt == ERR_MAX) begin
      res = ERR_MAX;
    end else begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/inverter_test_sequencer_pattern_gen.sv
// Combinational test-vector generator: even k walks a one-hot bit across the
// lanes, odd k is the complement of the preceding even vector.
module inv_pattern_gen
  #(parameter int WIDTH = 8)
  (
    input  logic [7:0]       k,
    output logic [WIDTH-1:0] v
  );

  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

  logic [31:0]      lane_s;
  logic [WIDTH-1:0] onehot_s;

  // Lane select j = (k >> 1) mod WIDTH, then the one-hot / complemented vector.
  always_comb begin
    lane_s   = {25'd0, k[7:1]} % 32'(WIDTH);
    onehot_s = LSB_ONE << lane_s;
    if (k[0]) begin
      v = ~onehot_s;
    end else begin
      v = onehot_s;
    end
  end

endmodule

// File: rtl/inverter_test_sequencer.sv
// Self-test controller for a WIDTH-lane inverter: drives a fixed vector
// sequence, checks ~vector at the end of each hold and reports run status.
module inverter_test_sequencer
  import inverter_test_sequencer_pkg::*;
  #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 10,
    parameter int NUM_VECTORS = 16
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       fail_idx
  );

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [7:0]    K_LAST    = 8'(NUM_VECTORS - 1);
  localparam logic [WIDTH-1:0] VEC_ZERO = WIDTH'(0);

  logic [2:0]       state_r, state_n;
  logic [HW-1:0]    hold_cnt_r, hold_cnt_n;
  logic [7:0]       k_r, k_n;
  logic [WIDTH-1:0] dut_in_r, dut_in_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             pass_r, pass_n;
  logic [7:0]       err_count_r, err_count_n;
  logic [7:0]       fail_idx_r, fail_idx_n;
  logic [7:0]       pat_k_s;
  logic [WIDTH-1:0] pat_v_s;
  logic             mismatch_s;

  // LOAD needs v(0); CHECK pre-computes the next vector v(k+1).
  always_comb begin
    if (state_r == ST_CHECK) begin
      pat_k_s = k_r + 8'd1;
    end else begin
      pat_k_s = 8'd0;
    end
  end

  inv_pattern_gen #(.WIDTH(WIDTH)) u_pattern (
    .k (pat_k_s),
    .v (pat_v_s)
  );

  // FSM next-state, vector sequencing and result bookkeeping.
  always_comb begin
    state_n     = state_r;
    hold_cnt_n  = hold_cnt_r;
    k_n         = k_r;
    dut_in_n    = dut_in_r;
    pass_n      = pass_r;
    err_count_n = err_count_r;
    fail_idx_n  = fail_idx_r;
    mismatch_s  = (dut_out != ~dut_in_r);

    case (state_r)
      ST_IDLE: begin
        dut_in_n = VEC_ZERO;
        if (abort) begin
          state_n = ST_IDLE;
        end else if (start) begin
          state_n     = ST_LOAD;
          hold_cnt_n  = HOLD_ZERO;
          k_n         = 8'd0;
          pass_n      = 1'b0;
          err_count_n = 8'd0;
          fail_idx_n  = FAIL_NONE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_n  = ST_IDLE;
          dut_in_n = VEC_ZERO;
          pass_n   = 1'b0;
        end else begin
          state_n    = ST_HOLD;
          dut_in_n   = pat_v_s;
          hold_cnt_n = HOLD_ZERO;
          k_n        = 8'd0;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_n  = ST_IDLE;
          dut_in_n = VEC_ZERO;
          pass_n   = 1'b0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_n    = ST_CHECK;
          hold_cnt_n = HOLD_ZERO;
        end else begin
          hold_cnt_n = hold_cnt_r + HOLD_ONE;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_n  = ST_IDLE;
          dut_in_n = VEC_ZERO;
          pass_n   = 1'b0;
        end else begin
          if (mismatch_s) begin
            err_count_n = sat_inc(err_count_r);
            if (fail_idx_r == FAIL_NONE) begin
              fail_idx_n = k_r;
            end else begin
              fail_idx_n = fail_idx_r;
            end
          end else begin
            err_count_n = err_count_r;
          end
          // pass must include the verdict of this final CHECK.
          if (k_r == K_LAST) begin
            state_n  = ST_DONE;
            dut_in_n = VEC_ZERO;
            pass_n   = (err_count_n == 8'd0);
          end else begin
            state_n  = ST_HOLD;
            k_n      = k_r + 8'd1;
            dut_in_n = pat_v_s;
          end
        end
      end
      ST_DONE: begin
        state_n  = ST_IDLE;
        dut_in_n = VEC_ZERO;
      end
      default: begin
        state_n  = ST_IDLE;
        dut_in_n = VEC_ZERO;
        pass_n   = 1'b0;
      end
    endcase

    busy_n = (state_n == ST_LOAD) || (state_n == ST_HOLD) || (state_n == ST_CHECK);
    done_n = (state_n == ST_DONE);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      hold_cnt_r  <= HOLD_ZERO;
      k_r         <= 8'd0;
      dut_in_r    <= VEC_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= 8'd0;
      fail_idx_r  <= FAIL_NONE;
    end else begin
      state_r     <= state_n;
      hold_cnt_r  <= hold_cnt_n;
      k_r         <= k_n;
      dut_in_r    <= dut_in_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      pass_r      <= pass_n;
      err_count_r <= err_count_n;
      fail_idx_r  <= fail_idx_n;
    end
  end

  assign dut_in    = dut_in_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_count_r;
  assign fail_idx  = fail_idx_r;

endmodule
